// File: rtl/i2s_rx.sv
// I2S receiver: synchronizes sck/ws/sd into clk, deserializes MSB-first words,
// and presents left/right stereo pairs on a valid/ready output with overflow flagging.
module i2s_rx #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sck,
  input  logic             ws,
  input  logic             sd,
  output logic [WIDTH-1:0] output_l_tdata,
  output logic [WIDTH-1:0] output_r_tdata,
  output logic             output_tvalid,
  input  logic             output_tready,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]       sck_sync, ws_sync, sd_sync;
  logic             sck_prev;
  logic [CW-1:0]    bit_cnt;
  logic             channel, last_ws, left_valid;
  logic [WIDTH-1:0] shift_reg, left_stage;

  logic             rise, ws_s, sd_s;
  logic [WIDTH-1:0] word;
  logic             done, left_done, pair_done, transfer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync <= '0;
      ws_sync  <= '0;
      sd_sync  <= '0;
      sck_prev <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[0], sck};
      ws_sync  <= {ws_sync[0], ws};
      sd_sync  <= {sd_sync[0], sd};
      sck_prev <= sck_sync[1];
    end
  end

  always_comb begin
    rise      = sck_sync[1] & ~sck_prev;
    ws_s      = ws_sync[1];
    sd_s      = sd_sync[1];
    word      = {shift_reg[WIDTH-2:0], sd_s};
    // Completion uses the pre-restart count/channel, so a ws edge still lands the previous LSB.
    done      = rise && (bit_cnt == CW'(1));
    left_done = done && !channel;
    pair_done = done && channel && left_valid;
    transfer  = output_tvalid && output_tready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt    <= '0;
      channel    <= 1'b0;
      last_ws    <= 1'b0;
      shift_reg  <= '0;
      left_stage <= '0;
      left_valid <= 1'b0;
    end else begin
      if (rise) begin
        if (bit_cnt != '0) begin
          shift_reg <= word;
          bit_cnt   <= bit_cnt - CW'(1);
        end
        if (ws_s != last_ws) begin
          bit_cnt <= CW'(WIDTH);
          channel <= ws_s;
          last_ws <= ws_s;
        end
      end
      if (left_done) begin
        left_stage <= word;
        left_valid <= 1'b1;
      end else if (pair_done) begin
        left_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      output_l_tdata <= '0;
      output_r_tdata <= '0;
      output_tvalid  <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (pair_done) begin
        output_l_tdata <= left_stage;
        output_r_tdata <= word;
        output_tvalid  <= 1'b1;
        overflow       <= output_tvalid && !output_tready;
      end else if (transfer) begin
        output_tvalid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/i2s_rx.md
I2S_RX -- requirements
Module: i2s_rx

Interface
REQ-001 Parameter WIDTH, default 16, is the bits per audio word and per channel.
REQ-002 clk  input  1  is the system clock; all state is in this single clock domain.
REQ-003 rst  input  1  is the reset; reset is asynchronous and active-high.
REQ-004 sck  input  1  is the I2S bit clock, asynchronous to clk.
REQ-005 ws  input  1  is the I2S word select: 0 means left, 1 means right.
REQ-006 sd  input  1  is the I2S serial data, MSB first.
REQ-007 output_l_tdata  output  WIDTH  carries the left sample of a stereo pair.
REQ-008 output_r_tdata  output  WIDTH  carries the right sample of a stereo pair.
REQ-009 output_tvalid  output  1  is high while a stereo pair is held.
REQ-010 output_tready  input  1  is the downstream accept signal.
REQ-011 overflow  output  1  is a one-clk pulse when an unaccepted pair is overwritten.

Function
REQ-012 sck, ws and sd SHALL each pass through a 2-flop synchronizer; all processing uses the synchronized versions.
REQ-013 An sck rising edge SHALL be detected as sync sck = 1 while its previously registered value = 0. Falling edges are ignored.
REQ-014 Operating range: clk >= 4x sck frequency, and each sck phase lasts >= 2 clk cycles. Behaviour outside this range is undefined.
REQ-015 On each rising edge, with bit_cnt > 0: shift sd into the LSB of the shift register, then decrement bit_cnt.
REQ-016 When bit_cnt goes 1 -> 0 the word is complete. It is routed by the channel flag latched at word start: channel 0 writes the left staging register and sets left_valid; channel 1 starts pair completion (REQ-019).
REQ-017 On each rising edge, ws SHALL be compared with the last_ws register. On a difference: bit_cnt <= WIDTH, channel <= ws, and last_ws <= ws.
REQ-018 When REQ-015/016 and REQ-017 fire on the same sck edge, the shift and completion SHALL use the old bit_cnt and channel before the restart. This delivers the LSB of the previous word on the ws-change edge, so the MSB is sampled one sck after the ws change.
REQ-019 Right word complete with left_valid = 1: load left staging and the right word into the output registers, set output_tvalid, and clear left_valid.
REQ-020 Right word complete with left_valid = 0: the right word SHALL be discarded with no output change.
REQ-021 A ws change while bit_cnt > 0 SHALL discard the partial word and restart the count. left_valid is unchanged by this.
REQ-022 A slot longer than WIDTH bits: the extra bits SHALL be ignored (bit_cnt stays 0).
REQ-023 Output latency: output_tvalid goes high on the 3rd clk edge counting from, and including, the edge that first registers sck = 1 of the LSB sample edge.
REQ-024 A transfer occurs when output_tvalid and output_tready are both high on a clk edge. output_tvalid then clears next cycle unless a new pair loads on that same edge.
REQ-025 While output_tvalid = 1 and no transfer occurs, the data outputs SHALL be stable, except as REQ-026 allows.
REQ-026 A new pair arriving while output_tvalid = 1 with no transfer on that edge: overwrite the output registers, keep output_tvalid = 1, and pulse overflow for exactly 1 clk.
REQ-027 A new pair arriving on the same edge as a transfer: load it, keep output_tvalid = 1, and keep overflow = 0.

Reset
REQ-028 While rst = 1 (asynchronously), the following SHALL be 0: output_l_tdata, output_r_tdata, output_tvalid, overflow, bit_cnt, channel, left_valid, last_ws, the shift and staging registers, and all synchronizer and edge flops.
REQ-029 Reset asserted mid-word SHALL discard all partial and unaccepted data.
REQ-030 After release, reception restarts at the first detected ws difference. A post-reset ws = 1 counts as a difference against last_ws = 0, and is handled by REQ-020.

Verification (WIDTH = 16, clk = 8x sck, slot = 16 sck)
REQ-031 Left 0xA5C3 and right 0x1234, output_tready = 1 -> exactly one beat (0xA5C3, 0x1234); output_tvalid high 1 clk; overflow = 0.
REQ-032 output_tready = 0 through frames (0x1111, 0x2222) then (0x3333, 0x4444) -> overflow pulses once at the second pair; the held beat is (0x3333, 0x4444).
REQ-033 rst released mid right slot with ws = 1, followed by a full frame (0x0F0F, 0xF0F0) -> the first and only beat is (0x0F0F, 0xF0F0).
REQ-034 20-bit left slot carrying 0xBEEF then 4 zeros, right 0x0001 -> beat (0xBEEF, 0x0001). A 12-bit left slot followed by a 16-bit right slot -> no beat.
REQ-035 rst pulsed between clk edges while output_tvalid = 1 -> output_tvalid and both data outputs read 0 before the next clk edge.
REQ-036 output_tready rising on the same edge a new pair loads -> old beat transferred, new beat held, overflow = 0.
